br_resolve_unit: RTL
====================

// Module: br_resolve_unit
// PURPOSE
//  Next-generation branch resolver for the 16-bit pipeline. Owns the architectural Z/V/N flag
//  register and evaluates 3-bit branch conditions against it, forwarding same-cycle flag writes.
//  Accepts one branch per cycle via valid/ready and stalls while a flag-setting op is in flight.
//  Returns a registered taken / next-PC / mispredict result one cycle after accept.
// PARAMETERS
//  ADDR_W     16  PC and target width
//  PC_INC     2   fall-through increment (bytes per instruction)
//  BHT_DEPTH  16  predictor entries, power of 2 (used only with BR_PREDICT_EN)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous active-high reset
//  flag_wr_en     in   3       per-flag write enable {Z,V,N}
//  flag_in        in   3       new flag values {Z,V,N}
//  flag_pend      in   1       flag-setting op in flight, flags not yet written
//  flush          in   1       pipeline flush; kills accept and pending result
//  br_valid       in   1       branch request valid
//  br_ready       out  1       unit can accept this cycle
//  br_cond        in   3       condition code
//  br_pc          in   ADDR_W  PC of branch
//  br_target      in   ADDR_W  taken target
//  pred_taken     out  1       prediction for current br_pc (comb.)
//  res_valid      out  1       result valid, 1-cycle pulse per accepted branch
//  res_taken      out  1       resolved direction
//  res_next_pc    out  ADDR_W  br_target if taken, else br_pc+PC_INC (mod 2^ADDR_W)
//  res_mispredict out  1       resolved direction != prediction at accept
//  flags_q        out  3       architectural flags {Z,V,N}
// BEHAVIOUR
//  - Reset: flags_q=0, res_valid=0, res_taken=0, res_next_pc=0, res_mispredict=0.
//  - Flags: each bit i loads flag_in[i] when flag_wr_en[i]; others hold.
//  - br_ready = ~flag_pend & ~rst. Accept = br_valid & br_ready & ~flush.
//  - Eval flags = flag_wr_en ? flag_in : flags_q per bit (same-cycle forwarding).
//  - Conditions (Z=f[2],V=f[1],N=f[0]): 000 NE ~Z; 001 EQ Z; 010 GT ~Z&~N; 011 LT N;
//    100 GE ~N; 101 LE N|Z; 110 OV V; 111 always 1.
//  - Latency 1: accept in cycle t -> res_* valid in t+1; else res_valid=0 (res data holds).
//  - Back-to-back accepts each cycle give one result per cycle; no internal queue.
//  - flush in t: no accept in t; res_valid forced 0 in t+1. Flag writes in t still apply.
//  - rst mid-stream: in-flight result dropped, flags cleared, predictor reinitialised.
//  - PC wrap: br_pc+PC_INC truncates to ADDR_W bits.
// CONFIGURATION
//  BR_PREDICT_EN defined: BHT of BHT_DEPTH 2-bit saturating counters, reset 2'b01;
//   index=(br_pc/PC_INC) mod BHT_DEPTH; pred_taken=ctr[1]. On res_valid, entry of the
//   resolved branch increments if taken (sat 3) / decrements if not (sat 0). Read and update
//   to same index in one cycle: read returns pre-update value. Unconditional (111) updates too.
//  BR_PREDICT_EN undefined: no BHT; pred_taken=0 (static not-taken); res_mispredict=res_taken.
// STRUCTURE
//  br_pkg: cond_e enum (NE,EQ,GT,LT,GE,LE,OV,UN), FLAG_Z=2/FLAG_V=1/FLAG_N=0 constants,
//   cond_eval(cond,flags) function shared with decode.
//  Sub-module br_bht (counter table, read/update ports); instantiated only under BR_PREDICT_EN.
// TESTING
//  1 rst; flag_wr_en=111,flag_in=100; next cyc cond=001,pc=0x0010,tgt=0x0040 -> t+1 taken, next_pc=0x0040.
//  2 flags_q=000; same cycle flag_wr_en=001,flag_in=001 + cond=011 -> taken (forwarded N).
//  3 all 8 conds x all 8 flag combos -> res_taken matches table; 111 always 1.
//  4 flag_pend=1 with br_valid -> br_ready=0, no res_valid; drop pend -> accepted, result t+1.
//  5 accept t, flush t+1 w/ br_valid -> t+1 res_valid=1 for first, t+2 res_valid=0.
//  6 pc=0xFFFE not-taken -> next_pc=0x0000; with BR_PREDICT_EN same pc taken 3x -> mispredict 1,0,0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-condition definitions for the resolver and the decode stage.
// Flag vectors are ordered {Z,V,N}.
package br_pkg;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_UN = 3'b111
    } cond_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    function automatic logic cond_eval(input cond_e cond, input logic [2:0] flags);
        logic z, v, n;
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        case (cond)
            COND_NE: cond_eval = ~z;
            COND_EQ: cond_eval = z;
            COND_GT: cond_eval = ~z & ~n;
            COND_LT: cond_eval = n;
            COND_GE: cond_eval = ~n;
            COND_LE: cond_eval = n | z;
            COND_OV: cond_eval = v;
            default: cond_eval = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table of 2-bit saturating counters with one async read port
// and one update port; a same-index read and update returns the pre-update value.
module br_bht #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [DEPTH];

    assign rd_taken = ctr[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (upd_taken && ctr[upd_idx] != 2'b11) begin
                ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
            end else if (!upd_taken && ctr[upd_idx] != 2'b00) begin
                ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolver: owns the {Z,V,N} flags, resolves one branch per cycle, result one cycle later.
// Optional dynamic prediction is enabled by defining BR_PREDICT_EN.
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int PC_INC    = 2,
    parameter int BHT_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        flag_wr_en,
    input  logic [2:0]        flag_in,
    input  logic              flag_pend,
    input  logic              flush,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pred_taken,
    output logic              res_valid,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_next_pc,
    output logic              res_mispredict,
    output logic [2:0]        flags_q
);

    logic              accept_p0;
    logic [2:0]        eval_flags_p0;
    logic              taken_p0;
    logic [ADDR_W-1:0] next_pc_p0;

    // Stage p0: forward same-cycle flag writes into the condition check
    assign br_ready      = ~flag_pend & ~rst;
    assign accept_p0     = br_valid & br_ready & ~flush;
    assign eval_flags_p0 = (flag_wr_en & flag_in) | (~flag_wr_en & flags_q);
    assign taken_p0      = cond_eval(cond_e'(br_cond), eval_flags_p0);
    assign next_pc_p0    = taken_p0 ? br_target : br_pc + ADDR_W'(PC_INC);

`ifdef BR_PREDICT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] rd_idx_p0;
    logic [IDX_W-1:0] res_idx_p1;

    assign rd_idx_p0 = IDX_W'(br_pc / PC_INC);

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            res_idx_p1 <= rd_idx_p0;
        end
    end

    br_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx_p0),
        .rd_taken  (pred_taken),
        .upd_en    (res_valid),
        .upd_idx   (res_idx_p1),
        .upd_taken (res_taken)
    );
`else
    assign pred_taken = 1'b0;
`endif

    // Stage p1: registered result; data holds when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q        <= 3'b000;
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_next_pc    <= '0;
            res_mispredict <= 1'b0;
        end else begin
            flags_q   <= eval_flags_p0;
            res_valid <= accept_p0;
            if (accept_p0) begin
                res_taken      <= taken_p0;
                res_next_pc    <= next_pc_p0;
                res_mispredict <= taken_p0 ^ pred_taken;
            end
        end
    end

endmodule
